instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Parametrised successor to the single-register fetch stage. It owns the instruction memory and a sequential loader port with a valid/ready handshake. It runs a state machine (IDLE/LOAD/RUN/HALT) and decouples fetch from decode through a FIFO fetch queue with a valid/ready output handshake. It sits between the debug/loader unit and the decode stage, and accepts branch/jump redirects from later stages.

## Interface
- SIZE, 32: instruction and PC width.
- MAX_INSTRUCTION, 64: instruction memory depth in words, a power of 2; ADDR_WIDTH = $clog2(MAX_INSTRUCTION).
- QUEUE_DEPTH, 4: fetch queue entries, a power of 2, ≥2.
- HALT_OPCODE, 32'hFFFFFFFF: encoding that stops fetching.
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_start  in  1  IDLE/HALT → RUN with PC=0.
- i_load_start  in  1  IDLE/HALT → LOAD; clears the write pointer.
- i_load_valid  in  1  loader word valid.
- i_load_data  in  SIZE  loader word.
- o_load_ready  out  1  loader word accepted when high together with i_load_valid.
- i_load_done  in  1  LOAD → IDLE.
- o_load_count  out  ADDR_WIDTH+1  words written in the current/last load.
- i_redirect  in  1  branch/jump taken.
- i_redirect_pc  in  SIZE  target byte address; bits [1:0] ignored.
- o_instruction  out  SIZE  queue head instruction.
- o_pc  out  SIZE  byte address of o_instruction.
- o_pc_plus4  out  SIZE  o_pc + 4, wrapped.
- o_valid  out  1  queue head valid.
- i_ready  in  1  decode accepts the head.
- o_state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
- o_halted  out  1  state==HALT and queue empty.

## Operation
- Reset (i_rst=0 at an edge):
  - state IDLE; PC, write pointer, o_load_count and queue pointers all 0; in-flight read cancelled.
  - Outputs: o_valid=0, o_load_ready=0, o_halted=0, o_instruction=0, o_pc=0, o_pc_plus4=4.
  - Memory contents are retained.
- IDLE:
  - No fetch.
  - i_load_start has priority over i_start when both are high.
- LOAD:
  - o_load_ready = (write pointer < MAX_INSTRUCTION).
  - Each i_load_valid && o_load_ready writes mem[wptr] and increments wptr and o_load_count.
  - Words offered when full are not accepted.
  - i_load_done → IDLE; a word handshaken in the same cycle is still written.
  - Redirect and start are ignored.
- RUN:
  - A read of mem[PC[ADDR_WIDTH+1:2]] is issued each cycle where (queue occupancy + in-flight reads) < QUEUE_DEPTH; PC then advances by 4.
  - The PC index wraps from the last word to 0; upper PC bits are kept at 0.
  - Read data is enqueued one cycle after the read is issued, tagged with its PC.
- Halt:
  - When an enqueued word equals HALT_OPCODE, it is still enqueued and delivered.
  - state → HALT; reads issued after it are discarded; no further reads.
- HALT:
  - The queue drains normally; o_halted rises once empty.
  - i_start or i_load_start leaves HALT.
  - i_redirect → RUN at the redirect target, flushing the queue.
- Redirect (RUN/HALT):
  - Queue flushed and in-flight read cancelled; PC ← {i_redirect_pc[SIZE-1:2], 2'b00}.
  - A head transfer (o_valid && i_ready) in the redirect cycle completes; all other entries are dropped.
- Queue: o_valid = not empty; a pop occurs on o_valid && i_ready. A push and pop in the same cycle keep occupancy unchanged, even when full.
- Reset mid-load or mid-run: state cleared per reset, in-flight data discarded, no partial write.

## Timing
- i_start sampled high at edge 0 → RUN from edge 0; PC 0 read issued in cycle 1; entry pushed at edge 2; o_valid=1 with o_pc=0 in cycle 2.
- Redirect sampled at edge r → target instruction is head with o_valid=1 in cycle r+2; o_valid=0 in cycle r+1.
- Sustained throughput is one instruction per cycle with i_ready held high.
- A held-off consumer fills the queue to QUEUE_DEPTH; no overrun and no dropped PCs.
- Loader: one word per cycle while o_load_ready=1; o_load_ready falls in the cycle after the MAX_INSTRUCTION-th write.
- o_halted rises in the cycle after the HALT_OPCODE entry is popped.

## Test plan
- Reset values:
  - Stimulus: hold i_rst=0 for 2 cycles, then release.
  - Response: o_state=0, o_valid=0, o_pc=0, o_pc_plus4=4, o_load_ready=0.
- Load then run:
  - Stimulus: load 5 words 0x11..0x55, i_load_done, i_start, i_ready=1.
  - Response: o_load_count=5; pairs (0,0x11),(4,0x22)…(16,0x55) delivered on consecutive cycles starting 2 cycles after start.
- Backpressure:
  - Stimulus: i_ready=0 for 10 cycles after start, then 1.
  - Response: the queue holds 4 entries; delivery resumes at PC 0,4,8,12,16 with no gaps or duplicates.
- Redirect:
  - Stimulus: i_redirect with i_redirect_pc=0x23 while the head is PC 8 and i_ready=1.
  - Response: PC 8 transfers; the next delivered entry is PC 0x20 two cycles later; the flushed PCs never appear.
- Halt:
  - Stimulus: mem[3]=HALT_OPCODE.
  - Response: PCs 0,4,8,12 delivered, then o_state=3; o_halted=1 after the pop; no PC 16; i_start restarts at PC 0.
- Wrap and load overflow:
  - Stimulus: MAX_INSTRUCTION=8; run past the last word; attempt a 9th load word.
  - Response: PC after 28 is 0; the 9th word is not accepted (o_load_ready=0); o_load_count=8.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage: owns instruction memory with a valid/ready loader port,
// runs IDLE/LOAD/RUN/HALT control and feeds decode through a small fetch FIFO.
module instruction_fetch_queue #(
    parameter int              SIZE            = 32,
    parameter int              MAX_INSTRUCTION = 64,
    parameter int              QUEUE_DEPTH     = 4,
    parameter logic [SIZE-1:0] HALT_OPCODE     = 32'hFFFFFFFF,
    localparam int             ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_load_start,
    input  logic                  i_load_valid,
    input  logic [SIZE-1:0]       i_load_data,
    output logic                  o_load_ready,
    input  logic                  i_load_done,
    output logic [ADDR_WIDTH:0]   o_load_count,
    input  logic                  i_redirect,
    input  logic [SIZE-1:0]       i_redirect_pc,
    output logic [SIZE-1:0]       o_instruction,
    output logic [SIZE-1:0]       o_pc,
    output logic [SIZE-1:0]       o_pc_plus4,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [1:0]            o_state,
    output logic                  o_halted
);

    localparam int PTR_WIDTH = $clog2(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH:0]  LOAD_LIMIT  = (ADDR_WIDTH+1)'(MAX_INSTRUCTION);
    localparam logic [PTR_WIDTH+1:0] DEPTH_LIMIT = (PTR_WIDTH+2)'(QUEUE_DEPTH);
    localparam logic [SIZE-1:0]      PC_MASK     = SIZE'(MAX_INSTRUCTION * 4 - 1) & ~SIZE'(3);
    localparam logic [SIZE-1:0]      WORD_MASK   = ~SIZE'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t              state;
    logic [SIZE-1:0]     pc;
    logic [ADDR_WIDTH:0] load_count;
    logic [SIZE-1:0]     mem [MAX_INSTRUCTION];

    logic                rd_valid;
    logic [SIZE-1:0]     rd_data;
    logic [SIZE-1:0]     rd_pc;

    logic [SIZE-1:0]     q_instr [QUEUE_DEPTH];
    logic [SIZE-1:0]     q_pc    [QUEUE_DEPTH];
    logic [PTR_WIDTH-1:0] q_head;
    logic [PTR_WIDTH-1:0] q_tail;
    logic [PTR_WIDTH:0]  q_count;
    logic [PTR_WIDTH+1:0] in_use;

    logic load_fire, issue, push, pop, halt_seen;
    logic load_take, start_take, redirect_take, flush;

    // Sequential fetch keeps the upper PC bits at zero and wraps within memory.
    function automatic logic [SIZE-1:0] next_pc(input logic [SIZE-1:0] p);
        next_pc = (p + SIZE'(4)) & PC_MASK;
    endfunction

    assign o_load_ready = (state == LOAD) && (load_count < LOAD_LIMIT);
    assign load_fire    = o_load_ready && i_load_valid;

    // In-flight reads reserve a slot so a held-off consumer can never overrun.
    assign in_use    = {1'b0, q_count} + {{(PTR_WIDTH+1){1'b0}}, rd_valid};
    assign issue     = (state == RUN) && (in_use < DEPTH_LIMIT);
    assign push      = rd_valid;
    assign pop       = o_valid && i_ready;
    assign halt_seen = (state == RUN) && push && (rd_data == HALT_OPCODE);

    assign load_take     = i_load_start && (state == IDLE || state == HALT);
    assign start_take    = i_start && !i_load_start && (state == IDLE || state == HALT);
    assign redirect_take = i_redirect && ((state == RUN) ||
                           (state == HALT && !i_load_start && !i_start));
    assign flush         = load_take || start_take || redirect_take;

    // Memory and fetch data path carry no reset so program contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (load_fire && i_rst) begin
            mem[load_count[ADDR_WIDTH-1:0]] <= i_load_data;
        end
        if (issue) begin
            rd_data <= mem[pc[ADDR_WIDTH+1:2]];
        end
        if (push) begin
            q_instr[q_tail] <= rd_data;
            q_pc[q_tail]    <= rd_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            pc         <= '0;
            load_count <= '0;
            rd_valid   <= 1'b0;
            rd_pc      <= '0;
            q_head     <= '0;
            q_tail     <= '0;
            q_count    <= '0;
        end else begin
            rd_valid <= issue && !flush && !halt_seen;
            if (issue) begin
                rd_pc <= pc;
            end

            if (redirect_take) begin
                pc <= i_redirect_pc & WORD_MASK;
            end else if (start_take) begin
                pc <= '0;
            end else if (issue) begin
                pc <= next_pc(pc);
            end

            if (load_take) begin
                load_count <= '0;
            end else if (load_fire) begin
                load_count <= load_count + 1'b1;
            end

            if (flush) begin
                q_head  <= '0;
                q_tail  <= '0;
                q_count <= '0;
            end else begin
                if (push) q_tail <= q_tail + 1'b1;
                if (pop)  q_head <= q_head + 1'b1;
                case ({push, pop})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: q_count <= q_count;
                endcase
            end

            case (state)
                IDLE: begin
                    if (load_take)       state <= LOAD;
                    else if (start_take) state <= RUN;
                end
                LOAD: begin
                    if (i_load_done) state <= IDLE;
                end
                RUN: begin
                    if (!redirect_take && halt_seen) state <= HALT;
                end
                HALT: begin
                    if (load_take)                         state <= LOAD;
                    else if (start_take || redirect_take) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_valid       = (q_count != '0);
    assign o_instruction = o_valid ? q_instr[q_head] : '0;
    assign o_pc          = o_valid ? q_pc[q_head] : '0;
    assign o_pc_plus4    = next_pc(o_pc);
    assign o_state       = state;
    assign o_halted      = (state == HALT) && !o_valid;
    assign o_load_count  = load_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with an 8-word memory; expected head
// transfers go into a scoreboard queue that a negedge monitor drains.
module tb_instruction_fetch_queue;

    localparam int          SIZE    = 32;
    localparam int          MAXI    = 8;
    localparam int          QD      = 4;
    localparam logic [31:0] HALT_OP = 32'hFFFFFFFF;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start, i_load_start, i_load_valid, i_load_done;
    logic [31:0] i_load_data;
    logic        o_load_ready;
    logic [3:0]  o_load_count;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_instruction, o_pc, o_pc_plus4;
    logic        o_valid, i_ready;
    logic [1:0]  o_state;
    logic        o_halted;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] image [MAXI];

    always #5 i_clk = ~i_clk;

    instruction_fetch_queue #(
        .SIZE(SIZE), .MAX_INSTRUCTION(MAXI), .QUEUE_DEPTH(QD), .HALT_OPCODE(HALT_OP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_load_start(i_load_start),
        .i_load_valid(i_load_valid), .i_load_data(i_load_data), .o_load_ready(o_load_ready),
        .i_load_done(i_load_done), .o_load_count(o_load_count), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .o_instruction(o_instruction), .o_pc(o_pc),
        .o_pc_plus4(o_pc_plus4), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state),
        .o_halted(o_halted)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic load_start,
                                 input logic load_done, input logic redirect,
                                 input logic [31:0] redirect_pc);
        i_start       = start;
        i_load_start  = load_start;
        i_load_done   = load_done;
        i_redirect    = redirect;
        i_redirect_pc = redirect_pc;
        tick();
        i_start      = 1'b0;
        i_load_start = 1'b0;
        i_load_done  = 1'b0;
        i_redirect   = 1'b0;
    endtask

    task automatic loadWord(input logic [31:0] data, input logic done);
        i_load_valid = 1'b1;
        i_load_data  = data;
        i_load_done  = done;
        tick();
        i_load_valid = 1'b0;
        i_load_done  = 1'b0;
    endtask

    task automatic pushExpect(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Program after the short reload: 0x11..0x55 then HALT at word 5.
    task automatic expectShortProgram();
        pushExpect(32'd0,  32'h11);
        pushExpect(32'd4,  32'h22);
        pushExpect(32'd8,  32'h33);
        pushExpect(32'd12, 32'h44);
        pushExpect(32'd16, 32'h55);
        pushExpect(32'd20, HALT_OP);
    endtask

    // Monitor: every head transfer must match the oldest scoreboard entry.
    always @(negedge i_clk) begin
        logic [63:0] e;
        if (i_rst === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer: got pc 0x%08h, expected no transfer", o_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("head_pc", o_pc, e[63:32]);
                checkOutput("head_instr", o_instruction, e[31:0]);
                if (e[36:34] != 3'd7) checkOutput("head_pc_plus4", o_pc_plus4, e[63:32] + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst = 1'b0; i_start = 1'b0; i_load_start = 1'b0; i_load_valid = 1'b0;
        i_load_done = 1'b0; i_load_data = '0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_ready = 1'b0;
        for (int i = 0; i < MAXI; i++) image[i] = 32'hA0 + i;
        image[5] = HALT_OP;

        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        $display("[TB] reset values");
        checkOutput("rst_state", 32'(o_state), 32'd0);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_pc", o_pc, 32'd0);
        checkOutput("rst_pc_plus4", o_pc_plus4, 32'd4);
        checkOutput("rst_load_ready", 32'(o_load_ready), 32'd0);
        checkOutput("rst_halted", 32'(o_halted), 32'd0);
        checkOutput("rst_instr", o_instruction, 32'd0);

        $display("[TB] full load and overflow");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("load_state", 32'(o_state), 32'd1);
        checkOutput("load_ready_start", 32'(o_load_ready), 32'd1);
        for (int i = 0; i < MAXI; i++) loadWord(image[i], 1'b0);
        checkOutput("load_ready_full", 32'(o_load_ready), 32'd0);
        checkOutput("load_count_full", 32'(o_load_count), 32'd8);
        loadWord(32'hDEAD_BEEF, 1'b0);
        checkOutput("load_count_overflow", 32'(o_load_count), 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("load_done_state", 32'(o_state), 32'd0);

        $display("[TB] short load, last word with done");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) loadWord(32'(i * 32'h11), i == 5);
        checkOutput("short_load_state", 32'(o_state), 32'd0);
        checkOutput("short_load_count", 32'(o_load_count), 32'd5);

        $display("[TB] run to halt");
        expectShortProgram();
        i_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("run_state", 32'(o_state), 32'd2);
        checkOutput("run_valid_c0", 32'(o_valid), 32'd0);
        tick();
        checkOutput("run_valid_c1", 32'(o_valid), 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            checkOutput("run_valid_stream", 32'(o_valid), 32'd1);
            checkOutput("run_pc_stream", o_pc, 32'(4 * k));
            if (k < 5) tick();
        end
        checkOutput("halt_state", 32'(o_state), 32'd3);
        checkOutput("halt_not_yet", 32'(o_halted), 32'd0);
        tick();
        checkOutput("halted", 32'(o_halted), 32'd1);
        repeat (3) tick();
        checkOutput("halt_no_more", 32'(o_valid), 32'd0);

        $display("[TB] load_start beats start");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("priority_state", 32'(o_state), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("priority_count", 32'(o_load_count), 32'd0);

        $display("[TB] backpressure");
        i_ready = 1'b0;
        expectShortProgram();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (9) tick();
        checkOutput("bp_state", 32'(o_state), 32'd2);
        checkOutput("bp_head_pc", o_pc, 32'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkOutput("bp_valid_stream", 32'(o_valid), 32'd1);
            checkOutput("bp_pc_stream", o_pc, 32'(4 * k));
            tick();
        end
        checkOutput("bp_halted", 32'(o_halted), 32'd1);

        $display("[TB] redirect");
        pushExpect(32'd0,   32'h11);
        pushExpect(32'd4,   32'h22);
        pushExpect(32'd8,   32'h33);
        pushExpect(32'h10,  32'h55);
        pushExpect(32'h14,  HALT_OP);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (4) tick();
        checkOutput("redir_head_before", o_pc, 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h13);
        checkOutput("redir_valid_r", 32'(o_valid), 32'd0);
        tick();
        checkOutput("redir_valid_r1", 32'(o_valid), 32'd0);
        tick();
        checkOutput("redir_valid_r2", 32'(o_valid), 32'd1);
        checkOutput("redir_target_pc", o_pc, 32'h10);
        tick();
        checkOutput("redir_halt_pc", o_pc, 32'h14);
        checkOutput("redir_halt_state", 32'(o_state), 32'd3);
        tick();
        checkOutput("redir_halted", 32'(o_halted), 32'd1);

        $display("[TB] wrap via redirect from halt");
        pushExpect(32'h18, image[6]);
        pushExpect(32'h1C, image[7]);
        expectShortProgram();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h18);
        checkOutput("wrap_state", 32'(o_state), 32'd2);
        repeat (3) tick();
        checkOutput("wrap_last_pc", o_pc, 32'h1C);
        tick();
        checkOutput("wrap_pc", o_pc, 32'd0);
        repeat (6) tick();
        checkOutput("wrap_halted", 32'(o_halted), 32'd1);

        $display("[TB] reset mid-run and mid-load");
        i_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        checkOutput("midrun_state", 32'(o_state), 32'd0);
        checkOutput("midrun_valid", 32'(o_valid), 32'd0);
        checkOutput("midrun_pc_plus4", o_pc_plus4, 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        i_rst = 1'b0;
        loadWord(32'h99, 1'b0);
        i_rst = 1'b1;
        checkOutput("midload_state", 32'(o_state), 32'd0);
        checkOutput("midload_count", 32'(o_load_count), 32'd0);
        expectShortProgram();
        i_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (9) tick();
        checkOutput("retain_halted", 32'(o_halted), 32'd1);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
